// File: rtl/bist_fail_logger_pkg.sv
// Shared types and default sizing for the BIST fail logger.
// Holds the run-control state encoding and the default RAM/log dimensions.
package bist_fail_logger_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOGGING = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/bist_fail_logger_fail_fifo.sv
// Fail-log storage: circular buffer with a separate occupancy counter,
// registered empty/full flags and a registered pop data port.
module fail_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop_req,
   input  logic [WIDTH-1:0] wr_data,
   output logic             push_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [OCC_W-1:0] occ_reg, occ_next;
   logic             empty_reg, empty_next;
   logic             full_reg, full_next;
   logic             rd_valid_reg, rd_valid_next;
   logic [WIDTH-1:0] rd_data_reg;
   logic             pop_ok;
   logic             push_ok;

   // A full log can still take a push when a pop frees a slot in the same cycle.
   assign pop_ok     = pop_req && !empty_reg;
   assign push_ready = !full_reg || pop_ok;
   assign push_ok    = push && push_ready;

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      occ_next      = occ_reg;
      rd_valid_next = 1'b0;
      if (clear) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         occ_next    = '0;
      end else begin
         rd_valid_next = pop_ok;
         if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
         endcase
      end
      empty_next = (occ_next == '0);
      full_next  = (occ_next == OCC_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         occ_reg      <= '0;
         empty_reg    <= 1'b1;
         full_reg     <= 1'b0;
         rd_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         occ_reg      <= occ_next;
         empty_reg    <= empty_next;
         full_reg     <= full_next;
         rd_valid_reg <= rd_valid_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem[wr_ptr_reg] <= wr_data;
   end

   // Read-before-write: a full-log push/pop on the same slot returns the old entry.
   always_ff @(posedge clk) begin
      if (rst)
         rd_data_reg <= '0;
      else if (pop_ok && !clear)
         rd_data_reg <= mem[rd_ptr_reg];
   end

   assign rd_valid = rd_valid_reg;
   assign rd_data  = rd_data_reg;
   assign empty    = empty_reg;
   assign full     = full_reg;

endmodule

// File: rtl/bist_fail_logger.sv
// BIST fail logger: tracks the test run, qualifies comparator failures,
// counts them and stores address/expected/actual in a FIFO for host readout.
module bist_fail_logger
   import bist_fail_logger_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bist_active,
   input  logic              cmp_valid,
   input  logic              error,
   input  logic [ADDR_W-1:0] fail_addr,
   input  logic [DATA_W-1:0] expected,
   input  logic [DATA_W-1:0] actual,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_exp,
   output logic [DATA_W-1:0] rd_act,
   output logic              log_empty,
   output logic              log_full,
   output logic              overflow,
   output logic [ADDR_W:0]   fail_count,
   output logic              run_done
);

   localparam int ENTRY_W = ADDR_W + 2 * DATA_W;

   state_t              state_reg, state_next;
   logic                start_run;
   logic                capture;
   logic                push_ready;
   logic                overflow_reg, overflow_next;
   logic [ADDR_W:0]     fail_count_reg, fail_count_next;
   logic [ENTRY_W-1:0]  wr_entry;
   logic [ENTRY_W-1:0]  rd_entry;

   always_comb begin
      state_next = state_reg;
      start_run  = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (bist_active) begin
               state_next = ST_LOGGING;
               start_run  = 1'b1;
            end
         end
         ST_LOGGING: begin
            if (!bist_active) state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   assign capture = (state_reg == ST_LOGGING) && bist_active && cmp_valid && error;

   always_comb begin
      fail_count_next = fail_count_reg;
      overflow_next   = overflow_reg;
      if (start_run) begin
         fail_count_next = '0;
         overflow_next   = 1'b0;
      end else if (capture) begin
         if (fail_count_reg != '1) fail_count_next = fail_count_reg + 1'b1;
         if (!push_ready)          overflow_next   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_count_reg <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         fail_count_reg <= fail_count_next;
         overflow_reg   <= overflow_next;
      end
   end

   assign wr_entry = {fail_addr, expected, actual};

   fail_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fail_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_run),
      .push       (capture),
      .pop_req    (rd_req),
      .wr_data    (wr_entry),
      .push_ready (push_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_entry),
      .empty      (log_empty),
      .full       (log_full)
   );

   assign rd_addr    = rd_entry[ENTRY_W-1 -: ADDR_W];
   assign rd_exp     = rd_entry[2*DATA_W-1 -: DATA_W];
   assign rd_act     = rd_entry[DATA_W-1:0];
   assign overflow   = overflow_reg;
   assign fail_count = fail_count_reg;
   assign run_done   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger: run control, FIFO order, overflow,
// full-log push/pop, run restart and mid-run reset.
module tb_bist_fail_logger;

   logic        clk = 1'b0;
   logic        rst;
   logic        bist_active;
   logic        cmp_valid;
   logic        error;
   logic [9:0]  fail_addr;
   logic [7:0]  expected;
   logic [7:0]  actual;
   logic        rd_req;
   logic        rd_valid;
   logic [9:0]  rd_addr;
   logic [7:0]  rd_exp;
   logic [7:0]  rd_act;
   logic        log_empty;
   logic        log_full;
   logic        overflow;
   logic [10:0] fail_count;
   logic        run_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bist_fail_logger dut (
      .clk         (clk),
      .rst         (rst),
      .bist_active (bist_active),
      .cmp_valid   (cmp_valid),
      .error       (error),
      .fail_addr   (fail_addr),
      .expected    (expected),
      .actual      (actual),
      .rd_req      (rd_req),
      .rd_valid    (rd_valid),
      .rd_addr     (rd_addr),
      .rd_exp      (rd_exp),
      .rd_act      (rd_act),
      .log_empty   (log_empty),
      .log_full    (log_full),
      .overflow    (overflow),
      .fail_count  (fail_count),
      .run_done    (run_done)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic log_err(input logic [9:0] a, input logic [7:0] e, input logic [7:0] x);
      cmp_valid = 1'b1;
      error     = 1'b1;
      fail_addr = a;
      expected  = e;
      actual    = x;
      tick();
      cmp_valid = 1'b0;
      error     = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [9:0] a, input logic [7:0] e, input logic [7:0] x);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      $display("pop %s: valid=%0d addr=0x%03h exp=0x%02h act=0x%02h", tag, rd_valid, rd_addr, rd_exp, rd_act);
      check_val({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check_val({tag, "_addr"},  32'(rd_addr),  32'(a));
      check_val({tag, "_exp"},   32'(rd_exp),   32'(e));
      check_val({tag, "_act"},   32'(rd_act),   32'(x));
      tick();
      check_val({tag, "_pulse_end"}, 32'(rd_valid), 32'd0);
      check_val({tag, "_hold"},      32'(rd_addr),  32'(a));
   endtask

   initial begin
      rst = 1'b1; bist_active = 1'b0; cmp_valid = 1'b0; error = 1'b0;
      fail_addr = '0; expected = '0; actual = '0; rd_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_val("rst_fail_count", 32'(fail_count), 32'd0);
      check_val("rst_empty",      32'(log_empty),  32'd1);
      check_val("rst_full",       32'(log_full),   32'd0);
      check_val("rst_overflow",   32'(overflow),   32'd0);
      check_val("rst_run_done",   32'(run_done),   32'd0);
      check_val("rst_rd_valid",   32'(rd_valid),   32'd0);
      check_val("rst_rd_addr",    32'(rd_addr),    32'd0);

      // Clean run: comparator active but never mismatching.
      bist_active = 1'b1;
      cmp_valid   = 1'b1;
      repeat (20) tick();
      bist_active = 1'b0;
      cmp_valid   = 1'b0;
      tick();
      $display("clean run: fail_count=%0d run_done=%0d", fail_count, run_done);
      check_val("clean_fail_count", 32'(fail_count), 32'd0);
      check_val("clean_empty",      32'(log_empty),  32'd1);
      check_val("clean_run_done",   32'(run_done),   32'd1);

      // Three failures, then FIFO-order readout.
      bist_active = 1'b1;
      tick();
      check_val("run2_run_done", 32'(run_done), 32'd0);
      log_err(10'h005, 8'hAA, 8'hAB);
      log_err(10'h1F0, 8'hAA, 8'hAB);
      log_err(10'h3FF, 8'hAA, 8'hAB);
      bist_active = 1'b0;
      tick();
      log_err(10'h123, 8'h11, 8'h22);
      check_val("three_fail_count", 32'(fail_count), 32'd3);
      check_val("three_not_empty",  32'(log_empty),  32'd0);
      pop_check("three_pop0", 10'h005, 8'hAA, 8'hAB);
      pop_check("three_pop1", 10'h1F0, 8'hAA, 8'hAB);
      pop_check("three_pop2", 10'h3FF, 8'hAA, 8'hAB);
      check_val("three_empty", 32'(log_empty), 32'd1);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check_val("empty_pop_valid", 32'(rd_valid), 32'd0);
      check_val("empty_pop_hold",  32'(rd_addr),  32'h3FF);

      // Ten failures into an eight-entry log.
      bist_active = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) log_err(10'(i * 7 + 3), 8'(i), 8'(8'hF0 ^ i));
      bist_active = 1'b0;
      tick();
      check_val("ovf_full",       32'(log_full),   32'd1);
      check_val("ovf_overflow",   32'(overflow),   32'd1);
      check_val("ovf_fail_count", 32'(fail_count), 32'd10);
      for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_pop%0d", i), 10'(i * 7 + 3), 8'(i), 8'(8'hF0 ^ i));
      check_val("ovf_empty",        32'(log_empty), 32'd1);
      check_val("ovf_not_full",     32'(log_full),  32'd0);
      check_val("ovf_still_sticky", 32'(overflow),  32'd1);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check_val("ovf_ninth_valid", 32'(rd_valid), 32'd0);

      // Full log with a simultaneous failure and pop.
      bist_active = 1'b1;
      tick();
      check_val("run4_fail_count", 32'(fail_count), 32'd0);
      check_val("run4_overflow",   32'(overflow),   32'd0);
      check_val("run4_empty",      32'(log_empty),  32'd1);
      for (int i = 0; i < 8; i++) log_err(10'(10'h200 + i), 8'(8'h10 + i), 8'(8'h20 + i));
      check_val("fullpp_full_before", 32'(log_full), 32'd1);
      cmp_valid = 1'b1; error = 1'b1; fail_addr = 10'h100; expected = 8'h55; actual = 8'h66;
      rd_req = 1'b1;
      tick();
      cmp_valid = 1'b0; error = 1'b0; rd_req = 1'b0;
      $display("full push+pop: valid=%0d addr=0x%03h full=%0d overflow=%0d", rd_valid, rd_addr, log_full, overflow);
      check_val("fullpp_valid",      32'(rd_valid),   32'd1);
      check_val("fullpp_addr",       32'(rd_addr),    32'h200);
      check_val("fullpp_overflow",   32'(overflow),   32'd0);
      check_val("fullpp_full",       32'(log_full),   32'd1);
      check_val("fullpp_fail_count", 32'(fail_count), 32'd9);
      bist_active = 1'b0;
      tick();
      for (int i = 1; i < 8; i++) pop_check($sformatf("fullpp_pop%0d", i), 10'(10'h200 + i), 8'(8'h10 + i), 8'(8'h20 + i));
      check_val("fullpp_one_left", 32'(log_empty), 32'd0);

      // Restart after DONE discards the leftover entry.
      bist_active = 1'b1;
      tick();
      check_val("run5_empty",      32'(log_empty),  32'd1);
      check_val("run5_fail_count", 32'(fail_count), 32'd0);
      check_val("run5_overflow",   32'(overflow),   32'd0);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check_val("run5_stale_pop", 32'(rd_valid), 32'd0);
      for (int i = 0; i < 4; i++) log_err(10'(10'h080 + i), 8'h33, 8'h44);
      check_val("run5_fail_count4", 32'(fail_count), 32'd4);

      // Reset mid-run wins over every other input.
      rst = 1'b1; cmp_valid = 1'b1; error = 1'b1; rd_req = 1'b1;
      tick();
      rst = 1'b0; bist_active = 1'b0; cmp_valid = 1'b0; error = 1'b0; rd_req = 1'b0;
      $display("mid-run reset: fail_count=%0d empty=%0d run_done=%0d", fail_count, log_empty, run_done);
      check_val("mrst_fail_count", 32'(fail_count), 32'd0);
      check_val("mrst_empty",      32'(log_empty),  32'd1);
      check_val("mrst_full",       32'(log_full),   32'd0);
      check_val("mrst_rd_valid",   32'(rd_valid),   32'd0);
      check_val("mrst_rd_addr",    32'(rd_addr),    32'd0);
      check_val("mrst_run_done",   32'(run_done),   32'd0);
      log_err(10'h0AA, 8'h01, 8'h02);
      check_val("idle_err_count", 32'(fail_count), 32'd0);
      check_val("idle_err_empty", 32'(log_empty),  32'd1);
      bist_active = 1'b1;
      log_err(10'h0BB, 8'h01, 8'h02);
      check_val("start_edge_count", 32'(fail_count), 32'd0);
      log_err(10'h0CC, 8'h03, 8'h04);
      check_val("logging_count", 32'(fail_count), 32'd1);
      bist_active = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
